// File: rtl/rf_2p_fifo_ctrl_if.sv
// Push/pop stream and RF port bundle for rf_2p_fifo_ctrl.
// The slave modport is the controller's view; master is the surrounding datapath plus RF macro.
interface rf_2p_fifo_ctrl_if #(
    parameter int WORDWD = 12,
    parameter int DWD    = 16,
    parameter int SIZE   = 1
);
    localparam int AWD = $clog2(WORDWD);
    localparam int CWD = $clog2(WORDWD + 1);

    logic                     i_clear;
    logic                     i_valid;
    logic                     o_ready;
    logic [SIZE-1:0][DWD-1:0] i_data;
    logic                     o_valid;
    logic                     i_ready;
    logic [SIZE-1:0][DWD-1:0] o_data;
    logic [CWD-1:0]           o_count;
    logic                     o_rf_write;
    logic [AWD-1:0]           o_rf_waddr;
    logic [SIZE-1:0][DWD-1:0] o_rf_wdata;
    logic                     o_rf_read;
    logic [AWD-1:0]           o_rf_raddr;
    logic [SIZE-1:0][DWD-1:0] i_rf_rdata;

    modport master (
        output i_clear,
        output i_valid,
        output i_data,
        output i_ready,
        output i_rf_rdata,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_count,
        input  o_rf_write,
        input  o_rf_waddr,
        input  o_rf_wdata,
        input  o_rf_read,
        input  o_rf_raddr
    );

    modport slave (
        input  i_clear,
        input  i_valid,
        input  i_data,
        input  i_ready,
        input  i_rf_rdata,
        output o_ready,
        output o_valid,
        output o_data,
        output o_count,
        output o_rf_write,
        output o_rf_waddr,
        output o_rf_wdata,
        output o_rf_read,
        output o_rf_raddr
    );
endinterface

// File: rtl/rf_2p_fifo_ctrl.sv
// Valid/ready FIFO controller driving a two-port register file with 1-cycle registered read.
// The RF output register acts as the pop stage; reads are only issued when that stage can be refilled.
module rf_2p_fifo_ctrl #(
    parameter int WORDWD = 12,
    parameter int DWD    = 16,
    parameter int SIZE   = 1,
    parameter int AWD    = $clog2(WORDWD),
    parameter int CWD    = $clog2(WORDWD + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rf_2p_fifo_ctrl_if.slave   bus
);

    logic [AWD-1:0] wptr_reg;
    logic [AWD-1:0] wptr_next;
    logic [AWD-1:0] rptr_reg;
    logic [AWD-1:0] rptr_next;
    logic [CWD-1:0] cnt_reg;
    logic [CWD-1:0] cnt_next;
    logic           out_v_reg;
    logic           out_v_next;

    logic           ready;
    logic           push;
    logic           rd;

    // Depth need not be a power of two, so wrap is an explicit compare.
    function automatic logic [AWD-1:0] ptr_inc(input logic [AWD-1:0] ptr);
        logic [AWD-1:0] res;
        if (ptr == AWD'(WORDWD - 1)) begin
            res = '0;
        end else begin
            res = ptr + AWD'(1);
        end
        return res;
    endfunction

    assign ready = (cnt_reg != CWD'(WORDWD)) && !bus.i_clear;
    assign push  = bus.i_valid && ready;
    // Refill the output register only when it is empty or being drained this cycle.
    assign rd    = (cnt_reg != '0) && (!out_v_reg || bus.i_ready) && !bus.i_clear;

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        cnt_next   = cnt_reg;
        out_v_next = out_v_reg;
        if (bus.i_clear) begin
            wptr_next  = '0;
            rptr_next  = '0;
            cnt_next   = '0;
            out_v_next = 1'b0;
        end else begin
            if (push) begin
                wptr_next = ptr_inc(wptr_reg);
            end
            if (rd) begin
                rptr_next = ptr_inc(rptr_reg);
            end
            if (push && !rd) begin
                cnt_next = cnt_reg + CWD'(1);
            end else if (rd && !push) begin
                cnt_next = cnt_reg - CWD'(1);
            end
            if (rd) begin
                out_v_next = 1'b1;
            end else if (bus.i_ready) begin
                out_v_next = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            cnt_reg   <= '0;
            out_v_reg <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            cnt_reg   <= cnt_next;
            out_v_reg <= out_v_next;
        end
    end

    // Addresses always show the live pointers; the enables qualify them.
    assign bus.o_ready    = ready;
    assign bus.o_count    = cnt_reg;
    assign bus.o_valid    = out_v_reg;
    assign bus.o_data     = bus.i_rf_rdata;
    assign bus.o_rf_write = push;
    assign bus.o_rf_waddr = wptr_reg;
    assign bus.o_rf_wdata = bus.i_data;
    assign bus.o_rf_read  = rd;
    assign bus.o_rf_raddr = rptr_reg;

endmodule
